// File: rtl/calc_key_sequencer.sv
// Calculator key sequencer: accumulates decimal operands from key strobes and
// evaluates chained signed add/sub (and optional iterative multiply).
// Optional feature macro: CALC_MUL_EN builds the shift-add multiplier and enables key 12.
module calc_key_sequencer #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             key_valid,
  input  logic [3:0]       key_code,
  output logic             key_ready,
  output logic [WIDTH-1:0] display_value,
  output logic [1:0]       op_pending,
  output logic             result_valid,
  output logic             overflow
);

  localparam int unsigned CntW = $clog2(MAX_DIGITS + 1);

  localparam logic [1:0] OpNone = 2'd0;
  localparam logic [1:0] OpAdd  = 2'd1;
  localparam logic [1:0] OpSub  = 2'd2;

  typedef enum logic [2:0] {StEnterA, StOpWait, StEnterB, StCompute, StShowResult} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] acc_a_q, acc_a_d, acc_b_q, acc_b_d;
  logic [CntW-1:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]       op_q, op_d, next_op_q, next_op_d;
  logic             chain_q, chain_d, ovf_q, ovf_d, rv_q, rv_d;

  logic             key_digit, key_oper, key_eq, key_clr;
  logic [1:0]       key_op;
  logic [WIDTH-1:0] digit;
  logic [WIDTH:0]   sum_ext;
  logic [WIDTH-1:0] res;
  logic             res_ovf, done;

  assign key_ready     = (state_q != StCompute);
  assign digit         = WIDTH'(key_code);
  // COMPUTE keeps showing the right operand that was on screen when it started
  assign display_value = (state_q == StEnterB || state_q == StCompute) ? acc_b_q : acc_a_q;
  assign op_pending    = op_q;
  assign result_valid  = rv_q;
  assign overflow      = ovf_q;

  // Decode an accepted strobe into key classes; rejected/reserved codes decode to nothing
  always_comb begin
    key_digit = 1'b0;
    key_oper  = 1'b0;
    key_eq    = 1'b0;
    key_clr   = 1'b0;
    key_op    = OpNone;
    if (key_valid && key_ready) begin
      if (key_code <= 4'd9) begin
        key_digit = 1'b1;
      end else begin
        case (key_code)
          4'd10: begin key_oper = 1'b1; key_op = OpAdd; end
          4'd11: begin key_oper = 1'b1; key_op = OpSub; end
`ifdef CALC_MUL_EN
          4'd12: begin key_oper = 1'b1; key_op = 2'd3; end
`endif
          4'd13: key_eq  = 1'b1;
          4'd14: key_clr = 1'b1;
          default: ;
        endcase
      end
    end
  end

  // Sign-extended add/sub; overflow when the two top bits disagree
  always_comb begin
    if (op_q == OpSub) begin
      sum_ext = {acc_a_q[WIDTH-1], acc_a_q} - {acc_b_q[WIDTH-1], acc_b_q};
    end else begin
      sum_ext = {acc_a_q[WIDTH-1], acc_a_q} + {acc_b_q[WIDTH-1], acc_b_q};
    end
  end

`ifdef CALC_MUL_EN
  localparam int unsigned MulCntW = $clog2(WIDTH + 1);
  localparam logic [1:0] OpMul = 2'd3;
  // Largest magnitudes representable for a positive and a negative product
  localparam logic [2*WIDTH-1:0] MulPos = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [2*WIDTH-1:0] MulNeg = {{WIDTH{1'b0}}, 1'b1, {(WIDTH-1){1'b0}}};

  logic [2*WIDTH-1:0] mcand_q, mcand_d, prod_q, prod_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d, abs_a, abs_b;
  logic [MulCntW-1:0] mul_cnt_q, mul_cnt_d;
  logic               mul_neg_q, mul_neg_d, start_compute;

  assign abs_a         = acc_a_q[WIDTH-1] ? -acc_a_q : acc_a_q;
  assign abs_b         = acc_b_q[WIDTH-1] ? -acc_b_q : acc_b_q;
  assign start_compute = (state_q == StEnterB) && (state_d == StCompute);

  // Shift-add on magnitudes: load on entry to COMPUTE, then one partial product per cycle
  always_comb begin
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    prod_d    = prod_q;
    mul_cnt_d = mul_cnt_q;
    mul_neg_d = mul_neg_q;
    if (start_compute) begin
      mcand_d   = {{WIDTH{1'b0}}, abs_a};
      mplier_d  = abs_b;
      prod_d    = '0;
      mul_cnt_d = '0;
      mul_neg_d = acc_a_q[WIDTH-1] ^ acc_b_q[WIDTH-1];
    end else if (state_q == StCompute && mul_cnt_q != MulCntW'(WIDTH)) begin
      if (mplier_q[0]) prod_d = prod_q + mcand_q;
      mcand_d   = mcand_q << 1;
      mplier_d  = mplier_q >> 1;
      mul_cnt_d = mul_cnt_q + MulCntW'(1);
    end
  end

  // Multiplier datapath registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      mcand_q   <= '0;
      mplier_q  <= '0;
      prod_q    <= '0;
      mul_cnt_q <= '0;
      mul_neg_q <= 1'b0;
    end else begin
      mcand_q   <= mcand_d;
      mplier_q  <= mplier_d;
      prod_q    <= prod_d;
      mul_cnt_q <= mul_cnt_d;
      mul_neg_q <= mul_neg_d;
    end
  end
`endif

  // Result of the current COMPUTE cycle and whether evaluation finishes now
  always_comb begin
    done    = 1'b1;
    res     = sum_ext[WIDTH-1:0];
    res_ovf = sum_ext[WIDTH] ^ sum_ext[WIDTH-1];
`ifdef CALC_MUL_EN
    if (op_q == OpMul) begin
      done    = (mul_cnt_q == MulCntW'(WIDTH));
      res     = mul_neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
      res_ovf = prod_q > (mul_neg_q ? MulNeg : MulPos);
    end
`endif
  end

  // Key sequencing next-state logic
  always_comb begin
    state_d     = state_q;
    acc_a_d     = acc_a_q;
    acc_b_d     = acc_b_q;
    digit_cnt_d = digit_cnt_q;
    op_d        = op_q;
    next_op_d   = next_op_q;
    chain_d     = chain_q;
    ovf_d       = ovf_q;
    rv_d        = 1'b0;
    if (key_clr) begin
      acc_a_d     = '0;
      acc_b_d     = '0;
      digit_cnt_d = '0;
      op_d        = OpNone;
      ovf_d       = 1'b0;
      state_d     = StEnterA;
    end else begin
      case (state_q)
        StEnterA: begin
          if (key_digit && digit_cnt_q < CntW'(MAX_DIGITS)) begin
            acc_a_d     = acc_a_q * WIDTH'(10) + digit;
            digit_cnt_d = digit_cnt_q + CntW'(1);
          end else if (key_oper) begin
            op_d    = key_op;
            state_d = StOpWait;
          end
        end
        StOpWait: begin
          if (key_digit) begin
            acc_b_d     = digit;
            digit_cnt_d = CntW'(1);
            state_d     = StEnterB;
          end else if (key_oper) begin
            op_d = key_op;
          end
        end
        StEnterB: begin
          if (key_digit && digit_cnt_q < CntW'(MAX_DIGITS)) begin
            acc_b_d     = acc_b_q * WIDTH'(10) + digit;
            digit_cnt_d = digit_cnt_q + CntW'(1);
          end else if (key_oper) begin
            chain_d   = 1'b1;
            next_op_d = key_op;
            state_d   = StCompute;
          end else if (key_eq) begin
            chain_d = 1'b0;
            state_d = StCompute;
          end
        end
        StCompute: begin
          if (done) begin
            acc_a_d = res;
            ovf_d   = ovf_q | res_ovf;
            if (chain_q) begin
              op_d    = next_op_q;
              state_d = StOpWait;
            end else begin
              rv_d    = 1'b1;
              state_d = StShowResult;
            end
          end
        end
        StShowResult: begin
          if (key_digit) begin
            acc_a_d     = digit;
            digit_cnt_d = CntW'(1);
            op_d        = OpNone;
            state_d     = StEnterA;
          end else if (key_oper) begin
            op_d    = key_op;
            state_d = StOpWait;
          end
        end
        default: state_d = StEnterA;
      endcase
    end
  end

  // State and operand registers
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= StEnterA;
      acc_a_q     <= '0;
      acc_b_q     <= '0;
      digit_cnt_q <= '0;
      op_q        <= OpNone;
      next_op_q   <= OpNone;
      chain_q     <= 1'b0;
      ovf_q       <= 1'b0;
      rv_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_a_q     <= acc_a_d;
      acc_b_q     <= acc_b_d;
      digit_cnt_q <= digit_cnt_d;
      op_q        <= op_d;
      next_op_q   <= next_op_d;
      chain_q     <= chain_d;
      ovf_q       <= ovf_d;
      rv_q        <= rv_d;
    end
  end

endmodule

// File: tb/tb_calc_key_sequencer.sv
// Self-checking bench for calc_key_sequencer: directed key sequences then random keys,
// compared against an arithmetic reference model of the calculator.
// Honours CALC_MUL_EN the same way as the design.
module tb_calc_key_sequencer;

  localparam int W    = 16;
  localparam int MAXD = 4;
`ifdef CALC_MUL_EN
  localparam bit MulEn = 1'b1;
`else
  localparam bit MulEn = 1'b0;
`endif
  localparam longint MaxV = (64'sd1 <<< (W - 1)) - 1;
  localparam longint MinV = -(64'sd1 <<< (W - 1));

  localparam int PhA = 0, PhOpw = 1, PhB = 2, PhShow = 3;

  logic         clk = 1'b0;
  logic         Reset;
  logic         key_valid;
  logic [3:0]   key_code;
  logic         key_ready;
  logic [W-1:0] display_value;
  logic [1:0]   op_pending;
  logic         result_valid;
  logic         overflow;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int     m_phase;
  longint m_a, m_b;
  int     m_cnt, m_op;
  bit     m_ovf;

  calc_key_sequencer #(.WIDTH(W), .MAX_DIGITS(MAXD)) dut (
    .clk          (clk),
    .Reset        (Reset),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .key_ready    (key_ready),
    .display_value(display_value),
    .op_pending   (op_pending),
    .result_valid (result_valid),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic longint wrap(input longint v);
    logic [W-1:0] lo;
    lo = v[W-1:0];
    return longint'($signed(lo));
  endfunction

  function automatic void model_reset();
    m_phase = PhA; m_a = 0; m_b = 0; m_cnt = 0; m_op = 0; m_ovf = 1'b0;
  endfunction

  function automatic int model_eval();
    longint t;
    case (m_op)
      1: t = m_a + m_b;
      2: t = m_a - m_b;
      3: t = m_a * m_b;
      default: t = m_a;
    endcase
    if (t > MaxV || t < MinV) m_ovf = 1'b1;
    m_a = wrap(t);
    return (m_op == 3) ? W + 1 : 1;
  endfunction

  // Apply one key to the model; cyc = COMPUTE cycles started, rv = result_valid expected
  function automatic void model_key(input int code, output int cyc, output bit rv);
    cyc = 0;
    rv  = 1'b0;
    if (code == 15 || (code == 12 && !MulEn)) return;
    if (code == 14) begin
      model_reset();
    end else if (code <= 9) begin
      case (m_phase)
        PhA:    if (m_cnt < MAXD) begin m_a = m_a * 10 + code; m_cnt++; end
        PhB:    if (m_cnt < MAXD) begin m_b = m_b * 10 + code; m_cnt++; end
        PhOpw:  begin m_b = code; m_cnt = 1; m_phase = PhB; end
        default: begin m_a = code; m_cnt = 1; m_op = 0; m_phase = PhA; end
      endcase
    end else if (code == 13) begin
      if (m_phase == PhB) begin
        cyc = model_eval();
        rv = 1'b1;
        m_phase = PhShow;
      end
    end else begin
      if (m_phase == PhB) cyc = model_eval();
      m_op = code - 9;
      m_phase = PhOpw;
    end
  endfunction

  function automatic logic [W-1:0] exp_disp();
    return (m_phase == PhB) ? m_b[W-1:0] : m_a[W-1:0];
  endfunction

  task automatic check_outs(input string tag, input bit exp_rv);
    chk({tag, " display"}, 64'(display_value), 64'(exp_disp()));
    chk({tag, " op_pending"}, 64'(op_pending), 64'(m_op));
    chk({tag, " overflow"}, 64'(overflow), 64'(m_ovf));
    chk({tag, " key_ready"}, 64'(key_ready), 64'd1);
    chk({tag, " result_valid"}, 64'(result_valid), 64'(exp_rv));
  endtask

  // Strobe one key; optionally strobe a digit during the first COMPUTE cycle
  task automatic press(input int code, input bit inject, input string tag);
    int cyc;
    bit rv;
    logic [W-1:0] held;
    held = exp_disp();
    model_key(code, cyc, rv);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'(code);
    @(posedge clk);
    #1 key_valid = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      chk({tag, " busy key_ready"}, 64'(key_ready), 64'd0);
      chk({tag, " busy display"}, 64'(display_value), 64'(held));
      chk({tag, " busy result_valid"}, 64'(result_valid), 64'd0);
      if (inject && i == 0) begin
        key_valid = 1'b1;
        key_code  = 4'd7;
        @(posedge clk);
        #1 key_valid = 1'b0;
      end
    end
    @(negedge clk);
    check_outs(tag, rv);
    if (rv) begin
      @(negedge clk);
      chk({tag, " pulse once"}, 64'(result_valid), 64'd0);
    end
  endtask

  function automatic int char2code(input byte c);
    if (c >= "0" && c <= "9") return int'(c - "0");
    case (c)
      "+": return 10;
      "-": return 11;
      "*": return 12;
      "=": return 13;
      "C": return 14;
      default: return 15;
    endcase
  endfunction

  task automatic type_str(input string s, input string tag);
    for (int i = 0; i < s.len(); i++) press(char2code(s[i]), 1'b0, tag);
  endtask

  // Start an evaluation with '=' and assert Reset partway through it
  task automatic reset_mid_compute(input string prep, input int depth);
    type_str(prep, "rst_prep");
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = 4'd13;
    @(posedge clk);
    #1 key_valid = 1'b0;
    for (int i = 0; i < depth; i++) @(negedge clk);
    chk("rst_mid in_compute", 64'(key_ready), 64'd0);
    Reset = 1'b1;
    #1;
    chk("rst_mid display", 64'(display_value), 64'd0);
    chk("rst_mid op_pending", 64'(op_pending), 64'd0);
    chk("rst_mid result_valid", 64'(result_valid), 64'd0);
    chk("rst_mid overflow", 64'(overflow), 64'd0);
    chk("rst_mid key_ready", 64'(key_ready), 64'd1);
    @(negedge clk);
    Reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int r, code;
    Reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'd0;
    model_reset();
    repeat (2) @(negedge clk);
    check_outs("reset", 1'b0);
    Reset = 1'b0;

    // 12 + 34 = 46
    type_str("12+34=", "add");
    chk("add value", 64'(display_value), 64'd46);
    chk("add op", 64'(op_pending), 64'd1);

    // 5 - 9 = -4
    type_str("C5-9=", "sub");
    chk("sub value", 64'(display_value), 64'hFFFC);
`ifdef CALC_MUL_EN
    type_str("*3=", "mul_neg");
    chk("mul_neg value", 64'(display_value), 64'hFFF4);
`endif

    // Fifth digit ignored
    type_str("C99999", "digits");
    chk("digits value", 64'(display_value), 64'd9999);
`ifdef CALC_MUL_EN
    type_str("*9999=", "mul_ovf");
    chk("mul_ovf flag", 64'(overflow), 64'd1);
    chk("mul_ovf value", 64'(display_value), 64'(99980001 % 65536));
`else
    type_str("+9999+9999+9999=", "add_ovf");
    chk("add_ovf flag", 64'(overflow), 64'd1);
`endif
    type_str("C", "clear");
    chk("clear overflow", 64'(overflow), 64'd0);
    chk("clear value", 64'(display_value), 64'd0);

    // Left-to-right chaining
`ifdef CALC_MUL_EN
    type_str("2+3*", "chain");
    chk("chain op", 64'(op_pending), 64'd3);
    type_str("4=", "chain_eq");
    chk("chain value", 64'(display_value), 64'd20);
`else
    type_str("2+3-", "chain");
    chk("chain op", 64'(op_pending), 64'd2);
    type_str("4=", "chain_eq");
    chk("chain value", 64'(display_value), 64'd1);
`endif

    // Digit strobed during COMPUTE is dropped
    type_str("C8+1", "drop_prep");
    press(13, 1'b1, "drop");
    chk("drop value", 64'(display_value), 64'd9);

`ifndef CALC_MUL_EN
    type_str("C7*2", "nomul");
    chk("nomul op", 64'(op_pending), 64'd0);
    chk("nomul value", 64'(display_value), 64'd72);
`endif

`ifdef CALC_MUL_EN
    reset_mid_compute("C9999*9999=*2", 5);
`else
    reset_mid_compute("C9999+9999+9999+9999+1", 1);
`endif
    check_outs("after_reset", 1'b0);

    // Random key stream against the model
    for (int k = 0; k < 200; k++) begin
      r = int'($urandom_range(0, 99));
      if (r < 55)      code = int'($urandom_range(0, 9));
      else if (r < 76) code = 10 + int'($urandom_range(0, 2));
      else if (r < 89) code = 13;
      else if (r < 92) code = 14;
      else             code = 15;
      press(code, 1'b0, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
